t08_spi: RTL and testbench

T08_SPI -- requirements
Module: t08_spi

---
 rtl/t08_spi_pkg.sv | 24 ++
 rtl/t08_spi_edge.sv | 21 ++
 rtl/t08_spi.sv | 134 +++++++++++++
 tb/tb_t08_spi.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_spi_pkg.sv
// Shared types and defaults for the t08_spi 8-bit parallel display-bus master.
package t08_spi_pkg;

  localparam int PARAM_BYTES_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD_LO = 3'd1,
    CMD_HI = 3'd2,
    PAR_LO = 3'd3,
    PAR_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Requested byte count limited to the width of the parameter bus.
  function automatic logic [3:0] clamp_count(input logic [3:0] cnt, input int max_bytes);
    logic [3:0] lim;
    lim = 4'(max_bytes);
    if (max_bytes < 16 && cnt > lim)
      return lim;
    return cnt;
  endfunction

endpackage

// File: rtl/t08_spi_edge.sv
// Rising-edge detector for the enable request; history resets high so a level
// already present at reset release is not mistaken for a new request.
module t08_spi_edge (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (nrst)
      din_q <= 1'b1;
    else
      din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/t08_spi.sv
// Parallel command/parameter bus master: one command byte then up to PARAM_BYTES
// parameter bytes. Define T08_SPI_EDGE_START_EN for edge-triggered start on enable.
module t08_spi
  import t08_spi_pkg::*;
#(
  parameter int PARAM_BYTES = PARAM_BYTES_DEF
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     enable,
  input  logic                     readwrite,
  input  logic [7:0]               command,
  input  logic [8*PARAM_BYTES-1:0] parameters,
  input  logic [3:0]               counter,
  output logic [7:0]               outputs,
  output logic                     wrx,
  output logic                     rdx,
  output logic                     csx,
  output logic                     dcx,
  output logic                     busy
);

  localparam int PW = 8 * PARAM_BYTES;

  state_t          state, state_nxt;
  logic            start;
  logic            load;
  logic            shift;
  logic            clr;
  logic [7:0]      cmd_q;
  logic [PW-1:0]   par_q;
  logic            rw_q;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_dec;

`ifdef T08_SPI_EDGE_START_EN
  t08_spi_edge u_edge (
    .clk  (clk),
    .nrst (nrst),
    .din  (enable),
    .rise (start)
  );
`else
  assign start = enable;
`endif

  assign cnt_dec = cnt_q - 4'd1;

  always_ff @(posedge clk) begin
    if (nrst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Latched transaction: loaded on start, shifted per parameter byte, cleared at DONE.
  always_ff @(posedge clk) begin
    if (nrst || clr) begin
      cmd_q <= '0;
      par_q <= '0;
      rw_q  <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      cmd_q <= command;
      par_q <= parameters;
      rw_q  <= readwrite;
      cnt_q <= clamp_count(counter, PARAM_BYTES);
    end else if (shift) begin
      par_q <= par_q << 8;
      cnt_q <= cnt_dec;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    busy      = 1'b0;
    csx       = 1'b1;
    dcx       = 1'b1;
    wrx       = 1'b1;
    rdx       = 1'b1;
    outputs   = 8'h00;
    case (state)
      IDLE, DONE: begin
        // DONE doubles as a start point so a held level request restarts immediately.
        if (start) begin
          load      = 1'b1;
          state_nxt = CMD_LO;
        end else begin
          clr       = (state == DONE);
          state_nxt = IDLE;
        end
      end
      CMD_LO: begin
        busy      = 1'b1;
        csx       = 1'b0;
        dcx       = 1'b0;
        wrx       = 1'b0;
        outputs   = cmd_q;
        state_nxt = CMD_HI;
      end
      CMD_HI: begin
        busy      = 1'b1;
        csx       = 1'b0;
        dcx       = 1'b0;
        outputs   = cmd_q;
        state_nxt = (cnt_q == 4'd0) ? DONE : PAR_LO;
      end
      PAR_LO: begin
        busy      = 1'b1;
        csx       = 1'b0;
        if (rw_q) begin
          wrx     = 1'b0;
          outputs = par_q[PW-1 -: 8];
        end else begin
          rdx     = 1'b0;
        end
        state_nxt = PAR_HI;
      end
      PAR_HI: begin
        busy      = 1'b1;
        csx       = 1'b0;
        if (rw_q)
          outputs = par_q[PW-1 -: 8];
        shift     = 1'b1;
        state_nxt = (cnt_dec == 4'd0) ? DONE : PAR_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_t08_spi.sv
// Directed bench for t08_spi: write/read framing, zero and clamped counts,
// reset precedence and held-enable behaviour in the configured start mode.
module tb_t08_spi;

  logic        clk;
  logic        nrst;
  logic        enable;
  logic        readwrite;
  logic [7:0]  command;
  logic [31:0] parameters;
  logic [3:0]  counter;
  logic [7:0]  outputs;
  logic        wrx, rdx, csx, dcx, busy;

  int tests;
  int fails;
  logic [12:0] cap [0:63];

  localparam logic [12:0] IDLE_V = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};

  t08_spi #(.PARAM_BYTES(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .readwrite  (readwrite),
    .command    (command),
    .parameters (parameters),
    .counter    (counter),
    .outputs    (outputs),
    .wrx        (wrx),
    .rdx        (rdx),
    .csx        (csx),
    .dcx        (dcx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic b, input logic c, input logic d,
                                     input logic w, input logic r, input logic [7:0] o);
    return {b, c, d, w, r, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      cap[base + i] = {busy, csx, dcx, wrx, rdx, outputs};
      tick();
    end
  endtask

  task automatic start_txn(input logic rw, input logic [7:0] cmd,
                           input logic [31:0] par, input logic [3:0] cnt);
    command    = cmd;
    parameters = par;
    counter    = cnt;
    readwrite  = rw;
    enable     = 1'b1;
    tick();
    enable     = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    nrst = 1'b1; enable = 1'b0; readwrite = 1'b0;
    command = 8'h00; parameters = '0; counter = 4'd0;
    tick(); tick();
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL reset_idle: got %h want %h", obs, IDLE_V);
    end
    nrst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write();
    logic [12:0] exp [0:11];
    logic [31:0] pv;
    int nb;
    pv = 32'hAA0FF033;
    start_txn(1'b1, 8'hFF, pv, 4'd4);
    // Change inputs mid-transaction; the latched copy must be used.
    command = 8'h5A; parameters = '0; counter = 4'd0; readwrite = 1'b0;
    capture(0, 12);
    exp[0] = pk(1, 0, 0, 0, 1, 8'hFF);
    exp[1] = pk(1, 0, 0, 1, 1, 8'hFF);
    for (int j = 0; j < 4; j++) begin
      exp[2 + 2*j] = pk(1, 0, 1, 0, 1, pv[31 - 8*j -: 8]);
      exp[3 + 2*j] = pk(1, 0, 1, 1, 1, pv[31 - 8*j -: 8]);
    end
    exp[10] = IDLE_V;
    exp[11] = IDLE_V;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      nb += int'(cap[i][12]);
      tests++;
      if (cap[i] !== exp[i]) begin
        fails++;
        $display("FAIL write_cycle%0d: got %h want %h", i, cap[i], exp[i]);
      end
    end
    tests++;
    if (nb !== 10) begin
      fails++;
      $display("FAIL write_busy_len: got %0d want 10", nb);
    end
  endtask

  task automatic test_read();
    logic [12:0] exp [0:11];
    start_txn(1'b0, 8'h29, 32'h12345678, 4'd4);
    capture(0, 12);
    exp[0] = pk(1, 0, 0, 0, 1, 8'h29);
    exp[1] = pk(1, 0, 0, 1, 1, 8'h29);
    for (int j = 0; j < 4; j++) begin
      exp[2 + 2*j] = pk(1, 0, 1, 1, 0, 8'h00);
      exp[3 + 2*j] = pk(1, 0, 1, 1, 1, 8'h00);
    end
    exp[10] = IDLE_V;
    exp[11] = IDLE_V;
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap[i] !== exp[i]) begin
        fails++;
        $display("FAIL read_cycle%0d: got %h want %h", i, cap[i], exp[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    logic [12:0] exp [0:3];
    int ncs, nbusy, nwr;
    start_txn(1'b1, 8'h2C, 32'hDEADBEEF, 4'd0);
    capture(0, 4);
    exp[0] = pk(1, 0, 0, 0, 1, 8'h2C);
    exp[1] = pk(1, 0, 0, 1, 1, 8'h2C);
    exp[2] = IDLE_V;
    exp[3] = IDLE_V;
    ncs = 0; nbusy = 0; nwr = 0;
    for (int i = 0; i < 4; i++) begin
      ncs   += int'(!cap[i][11]);
      nbusy += int'(cap[i][12]);
      nwr   += int'(!cap[i][9]);
      tests++;
      if (cap[i] !== exp[i]) begin
        fails++;
        $display("FAIL zero_cycle%0d: got %h want %h", i, cap[i], exp[i]);
      end
    end
    tests++;
    if (ncs !== 2 || nbusy !== 2 || nwr !== 1) begin
      fails++;
      $display("FAIL zero_counts: got cs=%0d busy=%0d wr=%0d want 2 2 1", ncs, nbusy, nwr);
    end
  endtask

  task automatic test_clamp();
    int nb;
    start_txn(1'b1, 8'h3A, 32'h11223344, 4'd9);
    capture(0, 12);
    nb = 0;
    for (int i = 0; i < 12; i++) nb += int'(cap[i][12]);
    tests++;
    if (nb !== 10) begin
      fails++;
      $display("FAIL clamp_busy_len: got %0d want 10", nb);
    end
    tests++;
    if (cap[8] !== pk(1, 0, 1, 0, 1, 8'h44) || cap[10] !== IDLE_V) begin
      fails++;
      $display("FAIL clamp_last_byte: got %h/%h want %h/%h",
               cap[8], cap[10], pk(1, 0, 1, 0, 1, 8'h44), IDLE_V);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs;
    start_txn(1'b1, 8'hB0, 32'hC1C2C3C4, 4'd4);
    tick(); tick(); tick(); tick();
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== pk(1, 0, 1, 0, 1, 8'hC2)) begin
      fails++;
      $display("FAIL rstmid_pre: got %h want %h", obs, pk(1, 0, 1, 0, 1, 8'hC2));
    end
    nrst = 1'b1;
    tick();
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL rstmid_edge: got %h want %h", obs, IDLE_V);
    end
    nrst = 1'b0;
    capture(0, 4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cap[i] !== IDLE_V) begin
        fails++;
        $display("FAIL rstmid_after%0d: got %h want %h", i, cap[i], IDLE_V);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [12:0] obs, exp;
    command = 8'h77; counter = 4'd0; readwrite = 1'b1;
    enable = 1'b1;
    nrst = 1'b1;
    tick();
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL rel_in_reset: got %h want %h", obs, IDLE_V);
    end
    nrst = 1'b0;
    tick();
`ifdef T08_SPI_EDGE_START_EN
    exp = IDLE_V;
`else
    exp = pk(1, 0, 0, 0, 1, 8'h77);
`endif
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL rel_first_cycle: got %h want %h", obs, exp);
    end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_enable_held();
    logic [12:0] pat [0:4];
    logic [12:0] exp;
    logic [12:0] obs;
    int nstart;
    command = 8'h3C; parameters = 32'h7E000000; counter = 4'd1; readwrite = 1'b1;
    pat[0] = pk(1, 0, 0, 0, 1, 8'h3C);
    pat[1] = pk(1, 0, 0, 1, 1, 8'h3C);
    pat[2] = pk(1, 0, 1, 0, 1, 8'h7E);
    pat[3] = pk(1, 0, 1, 1, 1, 8'h7E);
    pat[4] = IDLE_V;
    enable = 1'b1;
    tick();
    capture(0, 39);
    enable = 1'b0;
    capture(39, 1);
    nstart = 0;
    for (int i = 0; i < 40; i++) begin
      nstart += int'(cap[i] === pat[0]);
`ifdef T08_SPI_EDGE_START_EN
      exp = (i < 5) ? pat[i] : IDLE_V;
`else
      exp = pat[i % 5];
`endif
      tests++;
      if (cap[i] !== exp) begin
        fails++;
        $display("FAIL held_cycle%0d: got %h want %h", i, cap[i], exp);
      end
    end
    tests++;
`ifdef T08_SPI_EDGE_START_EN
    if (nstart !== 1) begin
      fails++;
      $display("FAIL held_starts: got %0d want 1", nstart);
    end
`else
    if (nstart !== 8) begin
      fails++;
      $display("FAIL held_starts: got %0d want 8", nstart);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    obs = {busy, csx, dcx, wrx, rdx, outputs};
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL held_settle: got %h want %h", obs, IDLE_V);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write();
    test_read();
    test_zero_count();
    test_clamp();
    test_reset_mid();
    test_reset_release();
    test_enable_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
